// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// State encoding, datapath widths and the buffered write-request record.
package wb_port_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   typedef enum logic {
      PIPE_PRI = 1'b0,
      FORCE    = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rn;
      logic [DATA_W-1:0]     data;
   } wr_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO for mult/div write requests.
// Full is independent of a same-cycle pop; no write-to-read bypass.
module wb_result_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  wr_req_t       wdata_i,
   input  logic          pop_i,
   output wr_req_t       rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   count_o
);

   wr_req_t       mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority,
// buffered mult/div results fill idle slots or force a stalled drain.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_wreg,
   input  logic [REG_ADDR_W-1:0] wb_rn,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  mc_valid,
   output logic                  mc_ready,
   input  logic [REG_ADDR_W-1:0] mc_rn,
   input  logic [DATA_W-1:0]     mc_data,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_wn,
   output logic [DATA_W-1:0]     rf_d,
   output logic                  stall_req,
   output logic                  busy
);

   localparam int CW   = $clog2(STARVE_LIMIT + 1);
   localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

   arb_state_e            state_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  rf_we_q, stall_q;
   logic [REG_ADDR_W-1:0] rf_wn_q;
   logic [DATA_W-1:0]     rf_d_q;

   wr_req_t   head, sel;
   logic      full, empty, push, pop, sel_v;
   logic      pipe_wr, last_pop, starve;
   logic [CNTW-1:0] occ;

   assign push     = mc_valid && !full;
   assign mc_ready = !full;
   assign busy     = !empty;
   assign pipe_wr  = wb_wreg && (wb_rn != '0);

   wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .wdata_i ('{rn: mc_rn, data: mc_data}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (occ)
   );

   always_comb begin
      pop   = 1'b0;
      sel_v = 1'b0;
      sel   = '0;
      unique case (state_q)
         FORCE: begin
            pop   = !empty;
            sel_v = !empty;
            sel   = head;
         end
         default: begin
            if (pipe_wr) begin
               sel_v = 1'b1;
               sel   = '{rn: wb_rn, data: wb_data};
            end else if (!empty) begin
               pop   = 1'b1;
               sel_v = 1'b1;
               sel   = head;
            end
         end
      endcase
   end

   // Counter clears on any pop or empty FIFO; saturates at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (empty || pop)
         cnt_d = '0;
      else if (cnt_q != CW'(STARVE_LIMIT))
         cnt_d = cnt_q + 1'b1;
   end

   assign last_pop = pop && (occ == CNTW'(1)) && !push;
   assign starve   = (state_q == PIPE_PRI) && !empty && !pop
                     && (cnt_q == CW'(STARVE_LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PIPE_PRI;
         cnt_q   <= '0;
         rf_we_q <= 1'b0;
         rf_wn_q <= '0;
         rf_d_q  <= '0;
         stall_q <= 1'b0;
      end else begin
         rf_we_q <= sel_v && (sel.rn != '0);
         if (sel_v) begin
            rf_wn_q <= sel.rn;
            rf_d_q  <= sel.data;
         end
         cnt_q <= cnt_d;
         unique case (state_q)
            FORCE: begin
               if (empty || last_pop) begin
                  state_q <= PIPE_PRI;
                  stall_q <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            default: begin
               if (starve) begin
                  state_q <= FORCE;
                  stall_q <= 1'b1;
               end
            end
         endcase
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_wn     = rf_wn_q;
   assign rf_d      = rf_d_q;
   assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected writes are queued by
// the stimulus and popped by a monitor whenever rf_we is seen high.
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_wreg;
   logic [4:0]  wb_rn;
   logic [31:0] wb_data;
   logic        mc_valid;
   logic        mc_ready;
   logic [4:0]  mc_rn;
   logic [31:0] mc_data;
   logic        rf_we;
   logic [4:0]  rf_wn;
   logic [31:0] rf_d;
   logic        stall_req;
   logic        busy;

   typedef struct {
      logic [4:0]  rn;
      logic [31:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   mon_en = 1'b0;

   wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .wb_wreg   (wb_wreg),
      .wb_rn     (wb_rn),
      .wb_data   (wb_data),
      .mc_valid  (mc_valid),
      .mc_ready  (mc_ready),
      .mc_rn     (mc_rn),
      .mc_data   (mc_data),
      .rf_we     (rf_we),
      .rf_wn     (rf_wn),
      .rf_d      (rf_d),
      .stall_req (stall_req),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic expw(input logic [4:0] rn, input logic [31:0] d);
      exp_t e;
      e.rn = rn;
      e.d  = d;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pipe(input logic we, input logic [4:0] rn,
                       input logic [31:0] d);
      wb_wreg = we;
      wb_rn   = rn;
      wb_data = d;
   endtask

   task automatic mc(input logic v, input logic [4:0] rn,
                     input logic [31:0] d);
      mc_valid = v;
      mc_rn    = rn;
      mc_data  = d;
   endtask

   always @(negedge clk) begin
      if (mon_en && rf_we === 1'b1) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_write: got r%0d=%0h want none",
                     rf_wn, rf_d);
         end else begin
            e = exp_q.pop_front();
            n_chk++;
            if (rf_wn === e.rn && rf_d === e.d) n_pass++;
            else $display("FAIL rf_write: got r%0d=%0h want r%0d=%0h",
                          rf_wn, rf_d, e.rn, e.d);
         end
      end
   end

   initial begin
      rst = 1'b1;
      pipe(1'b0, 5'd0, 32'h0);
      mc(1'b1, 5'd1, 32'h1);
      cyc();
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_stall", 32'(stall_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mc_ready", 32'(mc_ready), 32'd1);
      rst = 1'b0;
      mc(1'b0, 5'd0, 32'h0);
      mon_en = 1'b1;
      cyc();
      chk("rst_fifo_empty", 32'(busy), 32'd0);

      // idle-slot drain
      mc(1'b1, 5'd5, 32'hDEADBEEF);
      cyc();
      chk("drain_busy_after_push", 32'(busy), 32'd1);
      mc(1'b0, 5'd0, 32'h0);
      expw(5'd5, 32'hDEADBEEF);
      cyc();
      chk("drain_busy_fall", 32'(busy), 32'd0);
      chk("drain_rf_we", 32'(rf_we), 32'd1);
      cyc();

      // priority and starvation forced drain
      pipe(1'b1, 5'd3, 32'h11);
      mc(1'b1, 5'd7, 32'h22);
      expw(5'd3, 32'h11);
      cyc();
      chk("prio_stall_c0", 32'(stall_req), 32'd0);
      mc(1'b0, 5'd0, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         expw(5'd3, 32'h11);
         cyc();
         chk($sformatf("prio_stall_c%0d", i), 32'(stall_req),
             (i == 4) ? 32'd1 : 32'd0);
      end
      expw(5'd7, 32'h22);
      cyc();
      chk("prio_stall_release", 32'(stall_req), 32'd0);
      chk("prio_busy_clear", 32'(busy), 32'd0);
      expw(5'd3, 32'h11);
      cyc();
      pipe(1'b0, 5'd0, 32'h0);
      cyc();

      // full / backpressure, then push+pop during FORCE
      pipe(1'b1, 5'd3, 32'h11);
      mc(1'b1, 5'd10, 32'hA0);
      expw(5'd3, 32'h11);
      cyc();
      chk("full_ready_1", 32'(mc_ready), 32'd1);
      mc(1'b1, 5'd11, 32'hA1);
      expw(5'd3, 32'h11);
      cyc();
      chk("full_ready_2", 32'(mc_ready), 32'd0);
      mc(1'b1, 5'd12, 32'hA2);
      for (int i = 2; i <= 4; i++) begin
         expw(5'd3, 32'h11);
         cyc();
         chk($sformatf("full_ready_c%0d", i), 32'(mc_ready), 32'd0);
      end
      chk("full_force_entry", 32'(stall_req), 32'd1);
      expw(5'd10, 32'hA0);
      cyc();
      chk("force_ready_after_pop", 32'(mc_ready), 32'd1);
      chk("force_stall_1", 32'(stall_req), 32'd1);
      expw(5'd11, 32'hA1);
      cyc();
      mc(1'b0, 5'd0, 32'h0);
      chk("force_pushpop_stall", 32'(stall_req), 32'd1);
      chk("force_pushpop_busy", 32'(busy), 32'd1);
      chk("force_pushpop_ready", 32'(mc_ready), 32'd1);
      expw(5'd12, 32'hA2);
      cyc();
      chk("force_exit_stall", 32'(stall_req), 32'd0);
      chk("force_exit_busy", 32'(busy), 32'd0);
      expw(5'd3, 32'h11);
      cyc();
      pipe(1'b0, 5'd0, 32'h0);
      cyc();

      // pipeline r0 yields the slot to the FIFO
      mc(1'b1, 5'd9, 32'h33);
      cyc();
      mc(1'b0, 5'd0, 32'h0);
      pipe(1'b1, 5'd0, 32'h55);
      expw(5'd9, 32'h33);
      cyc();
      chk("r0_pipe_busy", 32'(busy), 32'd0);

      // FIFO r0 entry is consumed without a write
      mc(1'b1, 5'd0, 32'h44);
      cyc();
      mc(1'b0, 5'd0, 32'h0);
      cyc();
      chk("r0_fifo_busy", 32'(busy), 32'd0);
      chk("r0_fifo_we", 32'(rf_we), 32'd0);
      pipe(1'b0, 5'd0, 32'h0);
      cyc();

      // reset mid-operation discards buffered result
      pipe(1'b1, 5'd3, 32'h11);
      mc(1'b1, 5'd14, 32'hEE);
      expw(5'd3, 32'h11);
      cyc();
      chk("midrst_busy_pre", 32'(busy), 32'd1);
      mc(1'b0, 5'd0, 32'h0);
      rst = 1'b1;
      cyc();
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_we", 32'(rf_we), 32'd0);
      rst = 1'b0;
      pipe(1'b0, 5'd0, 32'h0);
      repeat (3) cyc();

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
